run_len_detector: RTL and testbench
===================================

Name: run_len_detector

Overview:
- Parametrised successor to the fixed four-in-a-row sequence FSM.
- Detects RUN_LEN consecutive identical samples of a 1-bit serial input, for either polarity.
- Reports the current run polarity and length, and counts completed detections.
- Used on the nvboard learning designs as a reusable serial-pattern detector driven from a switch or key input.

Parameters:
- RUN_LEN, 4, consecutive identical samples needed to assert out. Legal range 2 .. 2^CNT_W-1.
- CNT_W, 4, width of run_cnt.
- EVT_W, 8, width of evt_cnt.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  sample strobe; `in` is consumed only on cycles with en=1.
- in  input  1  serial data bit.
- clr  input  1  synchronous clear of evt_cnt.
- state  output  2  FSM state: 0=S_IDLE, 1=S_RUN0, 2=S_RUN1. Encoding 3 is never produced.
- run_cnt  output  CNT_W  length of the current run, saturating at RUN_LEN.
- out  output  1  detection flag.
- out_val  output  1  polarity of the detected run; valid when out=1, otherwise 0.
- evt_cnt  output  EVT_W  number of detections since reset or clr, saturating.

Behaviour:
- Reset (async, rst=1): state=S_IDLE, run_cnt=0, evt_cnt=0, out=0, out_val=0. Reset is effective mid-run and holds while rst=1. The first en=1 sample after release starts a new run.
- All state is registered. out and out_val are Moore outputs decoded from the registers, with no combinational path from `in`.
- en=0: state, run_cnt and evt_cnt hold; outputs stay stable.
- On en=1, next state and count:
  - From S_IDLE: in=0 goes to S_RUN0, in=1 goes to S_RUN1; run_cnt=1.
  - In S_RUN0 with in=0, or S_RUN1 with in=1: state holds; run_cnt = min(run_cnt+1, RUN_LEN).
  - In S_RUN0 with in=1, or S_RUN1 with in=0: switch to the opposite run state; run_cnt=1.
  - Any illegal state encoding: go to S_IDLE, run_cnt=0.
- Detection:
  - out = (run_cnt == RUN_LEN).
  - out_val = (state == S_RUN1) & out.
  - Latency: out rises on the cycle after the clock edge that samples the RUN_LEN-th identical bit.
  - Level mode: out stays high while the run continues. It drops the cycle after the edge that samples the opposite bit.
- Event counter:
  - Increments on the edge where run_cnt goes from RUN_LEN-1 to RUN_LEN, i.e. once per run.
  - Saturates at 2^EVT_W-1.
  - clr=1 sets it to 0. If clr and an increment occur on the same edge, clr wins and the result is 0.
  - clr acts regardless of en.
- Polarity switch at saturation: run_cnt goes to 1 and out drops. A further RUN_LEN-1 bits of the new polarity re-assert out; a total of RUN_LEN bits of the new polarity are needed.
- Width rule: run_cnt compares and saturates in CNT_W bits. RUN_LEN outside the legal range is a configuration error, flagged by elaboration-time check ($error in generate).

Optional Feature:
- Macro: RUN_LEN_DETECTOR_PULSE_EN.
- Defined: out is a single-cycle pulse, high only on the first cycle run_cnt equals RUN_LEN after the increment. out_val follows out. run_cnt and evt_cnt behave the same as in level mode. With en=0 on the following cycle, the pulse still lasts exactly one clk cycle.
- Undefined: level behaviour as specified above.

Test Plan:
- Reset then en=1, in=0 for 4 cycles → state=1, run_cnt=1,2,3,4; out=1 and out_val=0 on the cycle after the 4th sample; evt_cnt=1.
- Continue in=0 for 3 more cycles, then one in=1 → run_cnt stays at 4 and out stays 1 (level mode); evt_cnt remains 1; after the in=1 sample: state=2, run_cnt=1, out=0.
- Alternating 0/1 for 20 samples → run_cnt never exceeds 1; out never asserts; evt_cnt=0.
- 4 ones with en toggling 1,0,1,0,1,0,1 → holds on en=0; out=1 and out_val=1 only after the 4th en=1 sample; evt_cnt=1.
- Drive 300 runs of 4 alternating polarity with EVT_W=8 → evt_cnt saturates at 255. Then pulse clr on the same edge that completes a run → evt_cnt=0.
- Assert rst mid-run at run_cnt=3 → all outputs zero immediately without waiting for a clock edge. After release, 3 more zeros give run_cnt=3 and out=0. Rerun with RUN_LEN_DETECTOR_PULSE_EN defined and 6 zeros → out is high for exactly 1 cycle.

Source files
------------

// File: rtl/run_len_detector_if.sv
// run_len_detector_if: sample strobe/data/clear inputs and run/detection status of a run-length detector
// Ports (master drives, slave receives):
//   en, in, clr            : sample strobe, serial bit, event-counter clear
//   state, run_cnt         : current run state (0 idle, 1 zeros, 2 ones) and run length
//   out, out_val, evt_cnt  : detection flag, detected polarity, detection count
interface run_len_detector_if #(
    parameter int CNT_W = 4,
    parameter int EVT_W = 8
);
    logic             en;
    logic             in;
    logic             clr;
    logic [1:0]       state;
    logic [CNT_W-1:0] run_cnt;
    logic             out;
    logic             out_val;
    logic [EVT_W-1:0] evt_cnt;
    modport master(output en, in, clr, input state, run_cnt, out, out_val, evt_cnt);
    modport slave(input en, in, clr, output state, run_cnt, out, out_val, evt_cnt);
endinterface

// File: rtl/run_len_detector.sv
// run_len_detector: flags RUN_LEN consecutive identical samples of a serial bit, either polarity
// Ports: clk, rst (async, active high), bus (run_len_detector_if.slave: en/in/clr in,
//   state/run_cnt/out/out_val/evt_cnt out).
// Build option: RUN_LEN_DETECTOR_PULSE_EN makes out a one-cycle pulse per detection
//   instead of a level held for the rest of the run.
module run_len_detector #(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 4,
    parameter int EVT_W   = 8
) (
    input logic              clk,
    input logic              rst,
    run_len_detector_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN0 = 2'd1, S_RUN1 = 2'd2} state_t;
    localparam logic [CNT_W-1:0] RL      = CNT_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [EVT_W-1:0] EVT_ONE = EVT_W'(1);
    if (RUN_LEN < 2 || RUN_LEN > (2 ** CNT_W) - 1) begin : g_bad_cfg
        $error("run_len_detector: RUN_LEN out of range for CNT_W");
    end
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [EVT_W-1:0] evt_q;
    logic             inc;
    logic             det;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.en) begin
            case (state_q)
                S_IDLE: begin
                    state_d = bus.in ? S_RUN1 : S_RUN0;
                    cnt_d   = CNT_ONE;
                end
                S_RUN0, S_RUN1: begin
                    state_d = bus.in ? S_RUN1 : S_RUN0;
                    cnt_d   = (bus.in == (state_q == S_RUN1)) ? ((cnt_q == RL) ? RL : cnt_q + CNT_ONE) : CNT_ONE;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end
    // Only the edge that first brings the count to RUN_LEN counts as a detection.
    assign inc = (cnt_d == RL) && (cnt_q != RL);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            evt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            evt_q   <= bus.clr ? '0 : (inc && evt_q != '1) ? evt_q + EVT_ONE : evt_q;
        end
    end
`ifdef RUN_LEN_DETECTOR_PULSE_EN
    // Cleared on every edge regardless of en, so the pulse is exactly one clk wide.
    logic hit_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) hit_q <= 1'b0;
        else     hit_q <= inc;
    end
    assign det = hit_q;
`else
    assign det = (cnt_q == RL);
`endif
    assign bus.state   = state_q;
    assign bus.run_cnt = cnt_q;
    assign bus.out     = det;
    assign bus.out_val = (state_q == S_RUN1) & det;
    assign bus.evt_cnt = evt_q;
endmodule

// File: tb/tb_run_len_detector.sv
// tb_run_len_detector: randomized and directed checks of run_len_detector against a run-length model
module tb_run_len_detector;
    localparam int RL = 4, CNT_W = 4, EVT_W = 8, EVT_MAX = 255;
`ifdef RUN_LEN_DETECTOR_PULSE_EN
    localparam bit PULSE = 1'b1;
`else
    localparam bit PULSE = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst;
    run_len_detector_if #(.CNT_W(CNT_W), .EVT_W(EVT_W)) bus();
    run_len_detector #(.RUN_LEN(RL), .CNT_W(CNT_W), .EVT_W(EVT_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    // Model: true (unbounded) length of the current run, its polarity, detections, fresh detection flag.
    int streak = 0, evt = 0;
    bit pol = 1'b0, fresh = 1'b0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            streak = 0; evt = 0; fresh = 1'b0; pol = 1'b0;
        end else begin
            fresh = 1'b0;
            if (bus.en) begin
                if (streak > 0 && bus.in == pol) streak++;
                else begin pol = bus.in; streak = 1; end
                if (streak == RL) begin
                    fresh = 1'b1;
                    if (evt < EVT_MAX) evt++;
                end
            end
            if (bus.clr) evt = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            int e_cnt, e_state;
            bit e_out, e_val;
            e_cnt   = streak < RL ? streak : RL;
            e_out   = PULSE ? fresh : (streak >= RL);
            e_val   = e_out & pol;
            e_state = streak == 0 ? 0 : (pol ? 2 : 1);
            vectors++;
            if (int'(bus.state) != e_state || int'(bus.run_cnt) != e_cnt || bus.out != e_out ||
                bus.out_val != e_val || int'(bus.evt_cnt) != evt) begin
                miscompares++;
                $display("FAIL cycle t=%0t: got state=%0d run_cnt=%0d out=%0b out_val=%0b evt_cnt=%0d, want %0d %0d %0b %0b %0d",
                         $time, bus.state, bus.run_cnt, bus.out, bus.out_val, bus.evt_cnt, e_state, e_cnt, e_out, e_val, evt);
            end
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit e, input bit b, input bit c);
        bus.en = e; bus.in = b; bus.clr = c;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.en = 1'b0; bus.in = 1'b0; bus.clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int highs;
        bit b;
        rst = 1'b1; bus.en = 1'b0; bus.in = 1'b0; bus.clr = 1'b0;
        @(negedge clk);
        lit("rst_state", bus.state, 0);
        lit("rst_run_cnt", bus.run_cnt, 0);
        lit("rst_out", bus.out, 0);
        lit("rst_evt", bus.evt_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 0);
            lit("t1_run_cnt", bus.run_cnt, i);
            lit("t1_state", bus.state, 1);
        end
        lit("t1_out", bus.out, 1);
        lit("t1_out_val", bus.out_val, 0);
        lit("t1_evt", bus.evt_cnt, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0);
            lit("t2_run_cnt", bus.run_cnt, 4);
            lit("t2_out", bus.out, PULSE ? 0 : 1);
        end
        step(1, 1, 0);
        lit("t2_state", bus.state, 2);
        lit("t2_run_cnt", bus.run_cnt, 1);
        lit("t2_out", bus.out, 0);
        lit("t2_evt", bus.evt_cnt, 1);

        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1, i[0], 0);
            lit("alt_run_cnt", bus.run_cnt, 1);
            lit("alt_out", bus.out, 0);
        end
        lit("alt_evt", bus.evt_cnt, 0);

        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(!i[0], 1, 0);
            lit("en_run_cnt", bus.run_cnt, i / 2 + 1);
            lit("en_out", bus.out, i == 6 ? 1 : 0);
        end
        lit("en_out_val", bus.out_val, 1);
        lit("en_evt", bus.evt_cnt, 1);

        do_reset();
        for (int r = 0; r < 300; r++)
            for (int k = 0; k < 4; k++) step(1, r[0], 0);
        lit("sat_evt", bus.evt_cnt, EVT_MAX);
        for (int k = 0; k < 3; k++) step(1, 0, 0);
        step(1, 0, 1);
        lit("clr_evt", bus.evt_cnt, 0);
        lit("clr_out", bus.out, 1);

        do_reset();
        b = 1'b0;
        repeat (600) begin
            if ($urandom_range(3) == 0) b = ~b;
            step($urandom_range(3) != 0, b, $urandom_range(49) == 0);
        end

        do_reset();
        for (int k = 0; k < 3; k++) step(1, 0, 0);
        lit("mid_run_cnt", bus.run_cnt, 3);
        #2 rst = 1'b1;
        #1;
        lit("async_state", bus.state, 0);
        lit("async_run_cnt", bus.run_cnt, 0);
        lit("async_out", bus.out, 0);
        lit("async_out_val", bus.out_val, 0);
        lit("async_evt", bus.evt_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        highs = 0;
        for (int k = 0; k < 3; k++) step(1, 0, 0);
        lit("post_run_cnt", bus.run_cnt, 3);
        lit("post_out", bus.out, 0);
        for (int k = 0; k < 6; k++) begin
            step(k < 3, 0, 0);
            if (bus.out) highs++;
        end
        lit("out_high_cycles", highs, PULSE ? 1 : 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
